// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - instruction cache miss refill controller (burst collect, block install)
// Optional macro ICACHE_CWF_EN: critical-word-first refill with early-restart forwarding.
module icache_refill_ctrl #(
    parameter int PC_SIZE    = 32,
    parameter int MEM_WORD   = 32,
    parameter int BLOCK_SIZE = 512
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [PC_SIZE-1:0]    pc,
    input  logic                  hit,
    input  logic                  flush,
    output logic                  mem_req,
    output logic [PC_SIZE-1:0]    mem_addr,
    input  logic [MEM_WORD-1:0]   mem_word,
    input  logic                  word_ready,
    output logic                  we_cache,
    output logic [BLOCK_SIZE-1:0] block_out,
    output logic                  fwd_valid,
    output logic [MEM_WORD-1:0]   fwd_word,
    output logic                  stall
);

    localparam int WORDS     = BLOCK_SIZE / MEM_WORD;
    localparam int IDX_W     = $clog2(WORDS);
    localparam int CNT_W     = IDX_W + 1;
    localparam int OFF_BITS  = $clog2(BLOCK_SIZE / 8);
    localparam int WOFF_BITS = $clog2(MEM_WORD / 8);
    localparam logic [PC_SIZE-1:0] ONE = {{(PC_SIZE-1){1'b0}}, 1'b1};
`ifdef ICACHE_CWF_EN
    localparam logic [PC_SIZE-1:0] ALIGN_MASK = ~((ONE << WOFF_BITS) - ONE);
`else
    localparam logic [PC_SIZE-1:0] ALIGN_MASK = ~((ONE << OFF_BITS) - ONE);
`endif
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_INSTALL,
        S_SETTLE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  cancel_q, cancel_d;
    logic [PC_SIZE-1:0]    addr_q, addr_d;
    logic [BLOCK_SIZE-1:0] block_q, block_d;
    logic [IDX_W-1:0]      slot;

`ifdef ICACHE_CWF_EN
    logic                  fwd_valid_q, fwd_valid_d;
    logic [MEM_WORD-1:0]   fwd_word_q, fwd_word_d;

    // Beats arrive starting at the requested word and wrap around the block.
    assign slot = addr_q[WOFF_BITS +: IDX_W] + cnt_q[IDX_W-1:0];
`else
    assign slot = cnt_q[IDX_W-1:0];
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cancel_q <= 1'b0;
            addr_q   <= '0;
            block_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cancel_q <= cancel_d;
            addr_q   <= addr_d;
            block_q  <= block_d;
        end
    end

`ifdef ICACHE_CWF_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fwd_valid_q <= 1'b0;
            fwd_word_q  <= '0;
        end else begin
            fwd_valid_q <= fwd_valid_d;
            fwd_word_q  <= fwd_word_d;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cancel_d = cancel_q;
        addr_d   = addr_q;
        block_d  = block_q;
`ifdef ICACHE_CWF_EN
        fwd_valid_d = 1'b0;
        fwd_word_d  = fwd_word_q;
`endif
        case (state_q)
            S_IDLE: begin
                cancel_d = 1'b0;
                if (!hit && !flush) begin
                    addr_d  = pc & ALIGN_MASK;
                    cnt_d   = '0;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (flush) begin
                    cancel_d = 1'b1;
                end
                if (word_ready) begin
                    for (int s = 0; s < WORDS; s++) begin
                        if (slot == IDX_W'(s)) begin
                            block_d[BLOCK_SIZE-1-s*MEM_WORD -: MEM_WORD] = mem_word;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef ICACHE_CWF_EN
                    if (cnt_q == '0 && !cancel_q && !flush) begin
                        fwd_valid_d = 1'b1;
                        fwd_word_d  = mem_word;
                    end
`endif
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_INSTALL;
                    end
                end
            end
            S_INSTALL: begin
                if (flush) begin
                    cancel_d = 1'b1;
                end
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                cancel_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_req   = (state_q == S_REFILL);
    assign mem_addr  = addr_q;
    // A redirect arriving in the install cycle itself must still suppress the write.
    assign we_cache  = (state_q == S_INSTALL) && !cancel_q && !flush;
    assign block_out = block_q;
    assign stall     = (state_q != S_IDLE) || !hit;

`ifdef ICACHE_CWF_EN
    assign fwd_valid = fwd_valid_q;
    assign fwd_word  = fwd_word_q;
`else
    assign fwd_valid = 1'b0;
    assign fwd_word  = '0;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - scoreboard bench for icache_refill_ctrl (default params)
module tb_icache_refill_ctrl;

    logic         clk = 1'b0;
    logic         nrst;
    logic [31:0]  pc;
    logic         hit;
    logic         flush;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_word;
    logic         word_ready;
    logic         we_cache;
    logic [511:0] block_out;
    logic         fwd_valid;
    logic [31:0]  fwd_word;
    logic         stall;

    icache_refill_ctrl dut (
        .clk        (clk),
        .nrst       (nrst),
        .pc         (pc),
        .hit        (hit),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_word   (mem_word),
        .word_ready (word_ready),
        .we_cache   (we_cache),
        .block_out  (block_out),
        .fwd_valid  (fwd_valid),
        .fwd_word   (fwd_word),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic [31:0]  exp_addr_q[$];
    int           exp_len_q[$];
    logic [511:0] exp_blk_q[$];
    logic [31:0]  exp_fwd_q[$];
    int           exp_pulses = 0;
    int           we_pulses  = 0;
    logic [511:0] last_blk;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a request, install or forward.
    logic req_prev = 1'b0;
    int   req_len  = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req && !req_prev) begin
                req_len = 0;
                if (exp_addr_q.size() == 0) check("unexpected_mem_req", 1'b1, 1'b0);
                else check("mem_addr", mem_addr, exp_addr_q.pop_front());
            end
            if (mem_req) req_len++;
            if (!mem_req && req_prev) begin
                if (exp_len_q.size() == 0) check("unexpected_req_len", 1'b1, 1'b0);
                else check("mem_req_cycles", req_len, exp_len_q.pop_front());
            end
            req_prev = mem_req;
            if (we_cache) begin
                we_pulses++;
                if (exp_blk_q.size() == 0) check("unexpected_we_cache", 1'b1, 1'b0);
                else check("block_out", block_out, exp_blk_q.pop_front());
            end
            if (fwd_valid) begin
                if (exp_fwd_q.size() == 0) check("unexpected_fwd_valid", 1'b1, 1'b0);
                else check("fwd_word", fwd_word, exp_fwd_q.pop_front());
            end
        end
    end

    // One miss: gap idle cycles before each beat, flush on beat flush_beat (-1 none),
    // reset after rst_beat beats (-1 none).
    task automatic do_refill(input logic [31:0] pc_v, input logic [31:0] base,
                             input int gap, input int flush_beat, input int rst_beat);
        int           start;
        int           nbeats;
        logic         cancelled;
        logic [511:0] blk;
        logic [31:0]  exp_a;
`ifdef ICACHE_CWF_EN
        start = int'((pc_v >> 2) & 32'hF);
        exp_a = pc_v & ~32'h3;
`else
        start = 0;
        exp_a = pc_v & ~32'h3F;
`endif
        nbeats    = (rst_beat >= 0) ? rst_beat : 16;
        cancelled = (flush_beat >= 0 && flush_beat < nbeats);
        blk = '0;
        for (int k = 0; k < 16; k++) blk[511 - ((start + k) % 16) * 32 -: 32] = base + k;
        exp_addr_q.push_back(exp_a);
        exp_len_q.push_back(nbeats * (gap + 1));
`ifdef ICACHE_CWF_EN
        if (nbeats > 0 && flush_beat != 0) exp_fwd_q.push_back(base);
`endif
        if (rst_beat < 0 && !cancelled) begin
            exp_blk_q.push_back(blk);
            exp_pulses++;
            last_blk = blk;
        end

        hit = 1'b0;
        pc  = pc_v;
        tick();
        hit = 1'b1;
        pc  = 32'hDEAD_BEE0;
        for (int k = 0; k < nbeats; k++) begin
            for (int g = 0; g < gap; g++) begin
                word_ready = 1'b0;
                tick();
            end
            word_ready = 1'b1;
            mem_word   = base + k;
            flush      = (k == flush_beat);
            tick();
        end
        word_ready = 1'b0;
        flush      = 1'b0;

        if (rst_beat >= 0) begin
            nrst = 1'b0;
            #2;
            check("rst_mem_req", mem_req, 1'b0);
            check("rst_mem_addr", mem_addr, 32'h0);
            check("rst_block_out", block_out, 512'h0);
            check("rst_we_cache", we_cache, 1'b0);
            check("rst_fwd", {fwd_valid, fwd_word}, 33'h0);
            check("rst_stall", stall, 1'b0);
            tick();
            nrst = 1'b1;
            for (int s = 0; s < 3; s++) begin
                word_ready = 1'b1;
                mem_word   = 32'hBAD0 + s;
                @(negedge clk);
                check("stray_beat_mem_req", {mem_req, we_cache, stall}, 3'b000);
                @(posedge clk);
                #1;
            end
            word_ready = 1'b0;
            @(negedge clk);
            check("stray_block_out", block_out, 512'h0);
            tick();
        end else begin
            @(negedge clk);
            check("we_cache_install", we_cache, !cancelled);
            @(negedge clk);
            check("we_cache_settle", we_cache, 1'b0);
            @(posedge clk);
            #1;
            @(negedge clk);
            check("back_to_idle_stall", {stall, mem_req}, 2'b00);
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst       = 1'b0;
        pc         = 32'h0;
        hit        = 1'b0;
        flush      = 1'b0;
        mem_word   = 32'h0;
        word_ready = 1'b0;
        #12;
        check("reset_outputs", {mem_req, we_cache, fwd_valid, fwd_word, mem_addr}, 67'h0);
        check("reset_block", block_out, 512'h0);
        check("reset_stall_miss", stall, 1'b1);
        hit = 1'b1;
        #1;
        check("reset_stall_hit", stall, 1'b0);
        tick();
        nrst = 1'b1;
        tick();

        // Hits only; beats with no request must be ignored.
        for (int i = 0; i < 12; i++) begin
            word_ready = i[0];
            mem_word   = 32'h5000 + i;
            @(negedge clk);
            check("hit_only", {mem_req, we_cache, stall}, 3'b000);
            @(posedge clk);
            #1;
        end
        word_ready = 1'b0;

        // Miss during flush in IDLE: no refill.
        hit   = 1'b0;
        flush = 1'b1;
        tick();
        hit   = 1'b1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_miss_no_refill", mem_req, 1'b0);
        tick();

        do_refill(32'h0000_1044, 32'h100, 0, -1, -1);
        repeat (5) tick();
        check("block_retained", block_out, last_blk);
`ifdef ICACHE_CWF_EN
        check("cwf_slot1", block_out[479 -: 32], 32'h100);
        check("cwf_slot0", block_out[511 -: 32], 32'h10F);
`else
        check("msw", block_out[511 -: 32], 32'h100);
        check("lsw", block_out[31:0], 32'h10F);
`endif

        do_refill(32'h0000_1044, 32'h100, 1, -1, -1);
        do_refill(32'h0000_3000, 32'h900, 0, 4, -1);
        do_refill(32'h0000_2008, 32'h200, 0, -1, -1);
        do_refill(32'h0000_4000, 32'h700, 0, -1, 7);
        do_refill(32'h0000_5080, 32'h300, 0, -1, -1);
`ifdef ICACHE_CWF_EN
        do_refill(32'h0000_1044, 32'hA, 0, -1, -1);
        check("cwf_ex_slot1", block_out[479 -: 32], 32'hA);
        check("cwf_ex_slot0", block_out[511 -: 32], 32'h19);
`endif

        repeat (4) tick();
        check("pending_addr", exp_addr_q.size(), 0);
        check("pending_len", exp_len_q.size(), 0);
        check("pending_blk", exp_blk_q.size(), 0);
        check("pending_fwd", exp_fwd_q.size(), 0);
        check("we_pulse_count", we_pulses, exp_pulses);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
